// File: rtl/matrix_scan_capture_pkg.sv
// Shared definitions for the LED-matrix scan capture block: default geometry
// and the FSM state encoding.
package matrix_scan_capture_pkg;

  localparam int COLS_DEF       = 5;
  localparam int ROWS_DEF       = 7;
  localparam int MISS_LIMIT_DEF = 8;

  typedef enum logic {
    ST_HUNT    = 1'b0,
    ST_CAPTURE = 1'b1
  } state_e;

endpackage

// File: rtl/matrix_scan_capture_onehot_col_index.sv
// Classifies a column-activator sample as blank, a single column (with its
// index) or several simultaneous columns. Purely combinational.
module onehot_col_index
  import matrix_scan_capture_pkg::*;
#(
  parameter int COLS  = COLS_DEF,
  parameter int IDX_W = 3
) (
  input  logic [COLS-1:0]  i_act,
  output logic [IDX_W-1:0] o_index,
  output logic             o_blank,
  output logic             o_multi
);

  // Decode blank / multi flags and the index of the set bit
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latches).
    o_index = '0;
    o_blank = (i_act == '0);
    o_multi = ((i_act & (i_act - COLS'(1))) != '0);
    for (int i = 0; i < COLS; i++) begin
      if (i_act[i]) o_index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/matrix_scan_capture.sv
// Receiving end of the multiplexed LED-matrix column scan. Registers the
// activator/data pins, tracks the left-to-right column sequence and rebuilds
// the full frame in a shadow buffer, committing it when the scan wraps.
module matrix_scan_capture
  import matrix_scan_capture_pkg::*;
#(
  parameter int COLS           = COLS_DEF,
  parameter int ROWS           = ROWS_DEF,
  parameter int MISS_LIMIT     = MISS_LIMIT_DEF,
  parameter bit ACT_ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [COLS-1:0]      col_act,
  input  logic [ROWS-1:0]      col_data,
  output logic [COLS*ROWS-1:0] frame,
  output logic                 frame_valid,
  output logic                 locked,
  output logic                 scan_err,
  output logic [7:0]           frame_count
);

  localparam int IDX_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  localparam logic [IDX_W-1:0]  LAST_COL  = IDX_W'(COLS - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);

  logic [COLS-1:0]            r_act;
  logic [ROWS-1:0]            r_data;
  logic [IDX_W-1:0]           w_idx;
  logic                       w_blank;
  logic                       w_multi;
  logic                       w_col;
  logic                       w_hold;
  logic                       w_step;
  logic                       w_wrap;

  state_e                     r_state;
  logic [IDX_W-1:0]           r_cur;
  logic [MISS_W-1:0]          r_miss;
  logic [COLS-1:0][ROWS-1:0]  r_shadow;
  logic [COLS*ROWS-1:0]       r_frame;
  logic                       r_frame_valid;
  logic                       r_scan_err;
  logic [7:0]                 r_frame_count;

  // Input stage: one register on the pins, activator normalised to active-high
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_act  <= '0;
      r_data <= '0;
    end else begin
      r_act  <= ACT_ACTIVE_LOW ? ~col_act : col_act;
      r_data <= col_data;
    end
  end

  onehot_col_index #(
    .COLS  (COLS),
    .IDX_W (IDX_W)
  ) u_col_index (
    .i_act   (r_act),
    .o_index (w_idx),
    .o_blank (w_blank),
    .o_multi (w_multi)
  );

  // Relation of the registered sample to the column currently being assembled
  assign w_col  = !w_blank && !w_multi;
  assign w_hold = w_col && (w_idx == r_cur);
  assign w_step = w_col && (r_cur != '0) && (w_idx == r_cur - IDX_W'(1));
  assign w_wrap = w_col && (r_cur == '0) && (w_idx == LAST_COL);

  // Scan-tracking FSM: shadow assembly, frame commit, sync loss and error detection
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the shadow buffer is cleared on reset so a frame interrupted by reset never leaks into a later commit.
      r_state       <= ST_HUNT;
      r_cur         <= '0;
      r_miss        <= '0;
      r_shadow      <= '0;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
      r_scan_err    <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_frame_valid <= 1'b0;
      r_scan_err    <= 1'b0;
      case (r_state)
        ST_HUNT: begin
          if (w_col && (w_idx == LAST_COL)) begin
            r_shadow[LAST_COL] <= r_data;
            r_cur              <= LAST_COL;
            r_miss             <= '0;
            r_state            <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (w_blank) begin
            if (r_miss == MISS_LAST) begin
              r_state  <= ST_HUNT;
              r_shadow <= '0;
              r_miss   <= '0;
            end else begin
              r_miss <= r_miss + MISS_W'(1);
            end
          end else if (w_hold || w_step) begin
            r_shadow[w_idx] <= r_data;
            r_cur           <= w_idx;
            r_miss          <= '0;
          end else if (w_wrap) begin
            r_frame       <= r_shadow;
            r_frame_valid <= 1'b1;
            r_frame_count <= r_frame_count + 8'd1;
            // NOTE: non-blocking writes take effect in order, so the column write below overrides this clear.
            r_shadow           <= '0;
            r_shadow[LAST_COL] <= r_data;
            r_cur              <= LAST_COL;
            r_miss             <= '0;
          end else begin
            // Skip, backward jump or multi-column sample: the sequence is broken
            if (r_cur == '0) begin
              r_frame       <= r_shadow;
              r_frame_valid <= 1'b1;
              r_frame_count <= r_frame_count + 8'd1;
            end
            r_scan_err <= 1'b1;
            r_state    <= ST_HUNT;
            r_shadow   <= '0;
            r_miss     <= '0;
          end
        end
        default: r_state <= ST_HUNT;
      endcase
    end
  end

  assign frame       = r_frame;
  assign frame_valid = r_frame_valid;
  assign locked      = (r_state == ST_CAPTURE);
  assign scan_err    = r_scan_err;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Directed bench for matrix_scan_capture. Two instances share clock, reset and
// column data: one with active-high activators, one with inverted activators
// driven with the complement. Expected commits and errors are queued with the
// cycle they must appear on and popped when that cycle is sampled.
module tb_matrix_scan_capture;

  localparam logic [34:0] F1 = 35'h5_5AA5_A5A5;
  localparam logic [34:0] F2 = 35'h3_1357_9BDF;
  localparam logic [34:0] F3 = 35'h6_0F0F_1E1E;
  localparam logic [34:0] F4 = 35'h1_2345_6789;

  typedef struct {
    int          due;
    logic [34:0] frame;
  } exp_frame_t;

  logic        clk;
  logic        reset;
  logic [4:0]  col_act;
  logic [4:0]  col_act_n;
  logic [6:0]  col_data;

  logic [34:0] frame,       inv_frame;
  logic        frame_valid, inv_frame_valid;
  logic        locked,      inv_locked;
  logic        scan_err,    inv_scan_err;
  logic [7:0]  frame_count, inv_frame_count;

  exp_frame_t  frame_q[$];
  int          err_q[$];
  int          cyc;
  int          n_cmp;
  int          n_mis;
  logic [7:0]  exp_count;
  logic [34:0] f4_exp;

  matrix_scan_capture #(.ACT_ACTIVE_LOW(1'b0)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .col_act     (col_act),
    .col_data    (col_data),
    .frame       (frame),
    .frame_valid (frame_valid),
    .locked      (locked),
    .scan_err    (scan_err),
    .frame_count (frame_count)
  );

  matrix_scan_capture #(.ACT_ACTIVE_LOW(1'b1)) u_dut_inv (
    .clk         (clk),
    .reset       (reset),
    .col_act     (col_act_n),
    .col_data    (col_data),
    .frame       (inv_frame),
    .frame_valid (inv_frame_valid),
    .locked      (inv_locked),
    .scan_err    (inv_scan_err),
    .frame_count (inv_frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] col_of(input logic [34:0] f, input int k);
    return f[k*7 +: 7];
  endfunction

  // Expectation for a sample about to be driven: visible two edges later
  task automatic push_frame(input logic [34:0] f);
    exp_frame_t e;
    e.due   = cyc + 2;
    e.frame = f;
    frame_q.push_back(e);
  endtask

  task automatic push_err();
    err_q.push_back(cyc + 2);
  endtask

  // Drive one sample, clock it, then score both instances
  task automatic step(input logic [4:0] act, input logic [6:0] data);
    bit         fv_exp;
    bit         er_exp;
    exp_frame_t e;
    col_act   = act;
    col_act_n = ~act;
    col_data  = data;
    @(posedge clk);
    cyc++;
    #1;
    fv_exp = (frame_q.size() > 0) && (frame_q[0].due == cyc);
    check("frame_valid",     64'(frame_valid),     64'(fv_exp));
    check("inv_frame_valid", 64'(inv_frame_valid), 64'(fv_exp));
    if (fv_exp) begin
      e = frame_q.pop_front();
      exp_count++;
      check("frame",           64'(frame),           64'(e.frame));
      check("inv_frame",       64'(inv_frame),       64'(e.frame));
      check("frame_count",     64'(frame_count),     64'(exp_count));
      check("inv_frame_count", 64'(inv_frame_count), 64'(exp_count));
    end
    er_exp = (err_q.size() > 0) && (err_q[0] == cyc);
    if (er_exp) void'(err_q.pop_front());
    check("scan_err",     64'(scan_err),     64'(er_exp));
    check("inv_scan_err", 64'(inv_scan_err), 64'(er_exp));
  endtask

  task automatic col(input int k, input logic [6:0] data);
    step(5'(1 << k), data);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(5'b00000, 7'h00);
  endtask

  task automatic scan_cols(input logic [34:0] f, input int hi, input int lo);
    for (int k = hi; k >= lo; k--) col(k, col_of(f, k));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_frame"},       64'(frame),           64'd0);
    check({tag, "_inv_frame"},   64'(inv_frame),       64'd0);
    check({tag, "_fv"},          64'(frame_valid),     64'd0);
    check({tag, "_locked"},      64'(locked),          64'd0);
    check({tag, "_inv_locked"},  64'(inv_locked),      64'd0);
    check({tag, "_err"},         64'(scan_err),        64'd0);
    check({tag, "_count"},       64'(frame_count),     64'd0);
    check({tag, "_inv_count"},   64'(inv_frame_count), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    frame_q.delete();
    err_q.delete();
    exp_count = '0;
    step(5'b00000, 7'h00);
    step(5'b00000, 7'h00);
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    col_act   = '0;
    col_act_n = '1;
    col_data  = '0;
    cyc       = 0;
    n_cmp     = 0;
    n_mis     = 0;
    exp_count = '0;

    // 1: reset state, then a clean scan repeated
    do_reset();
    check_cleared("reset");
    scan_cols(F1, 4, 0);
    push_frame(F1);
    col(4, col_of(F1, 4));
    scan_cols(F1, 3, 0);
    check("t1_locked",     64'(locked),     64'd1);
    check("t1_inv_locked", 64'(inv_locked), 64'd1);
    check("t1_count",      64'(frame_count), 64'd1);

    // 2: join mid-scan at column 2
    do_reset();
    scan_cols(F2, 2, 0);
    check("t2_hunt_locked", 64'(locked), 64'd0);
    scan_cols(F2, 4, 0);
    push_frame(F2);
    col(4, col_of(F3, 4));

    // 3: two activator bits after column 3 -> error, frame held
    col(3, 7'h2A);
    push_err();
    step(5'b01100, 7'h11);
    blank(1);
    check("t3_locked",     64'(locked),     64'd0);
    check("t3_inv_locked", 64'(inv_locked), 64'd0);
    check("t3_frame_held", 64'(frame),      64'(F2));
    blank(1);

    // 4: eight blanks lose sync; seven do not
    col(4, 7'h33);
    col(3, 7'h44);
    blank(8);
    check("t4_locked_7", 64'(locked), 64'd1);
    blank(1);
    check("t4_locked_8", 64'(locked), 64'd0);
    scan_cols(F3, 4, 3);
    blank(7);
    check("t4_locked_after_7", 64'(locked), 64'd1);
    scan_cols(F3, 2, 0);
    push_frame(F3);
    col(4, col_of(F4, 4));

    // 5: held column, last data wins
    scan_cols(F4, 3, 2);
    col(1, 7'h01);
    col(1, 7'h02);
    col(1, 7'h7F);
    col(0, col_of(F4, 0));
    f4_exp = F4;
    f4_exp[13:7] = 7'h7F;
    push_frame(f4_exp);
    col(4, col_of(F1, 4));
    col(3, col_of(F1, 3));
    check("t5_col1", 64'(frame[13:7]), 64'h7F);

    // 6: mid-frame reset during column 2, then counter wrap
    reset = 1'b0;
    col(2, col_of(F1, 2));
    reset = 1'b1;
    exp_count = '0;
    check_cleared("midreset");
    scan_cols(F1, 4, 0);
    for (int n = 0; n < 256; n++) begin
      push_frame(F1);
      scan_cols(F1, 4, 0);
    end
    check("t6_count_wrap",     64'(frame_count),     64'd0);
    check("t6_inv_count_wrap", 64'(inv_frame_count), 64'd0);

    // Multi-column sample with a complete shadow: commit and error together
    push_frame(F1);
    push_err();
    step(5'b10001, 7'h55);
    blank(1);
    check("t6_multi_locked", 64'(locked), 64'd0);
    blank(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
